// File: rtl/pipe_ctrl_pkg.sv
// Package: pipe_ctrl_pkg
// Shared definitions for the 5-stage pipeline controller: default sizing,
// the canonical NOP encoding, the controller mode enum and the bundle of
// enable/flush bits that drives the pipeline registers.
package pipe_ctrl_pkg;

  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_WB_DIST    = 3;
  localparam int DEF_CNT_W      = 32;

  // addi x0, x0, 0 -- what IF/ID loads when flushed
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    RAW,
    BRANCH,
    MEMWAIT
  } pipe_mode_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } pipe_ctrl_t;

  // Enable/flush pattern for each mode. A RAW stall freezes PC and IF/ID,
  // then injects a bubble into ID/EX so older instructions keep draining.
  function automatic pipe_ctrl_t mode_to_ctrl(input pipe_mode_e mode);
    pipe_ctrl_t c;
    c = '0;
    case (mode)
      RUN: begin
        c.pc_en     = 1'b1;
        c.if_id_en  = 1'b1;
        c.id_ex_en  = 1'b1;
        c.ex_mem_en = 1'b1;
        c.mem_wb_en = 1'b1;
      end
      RAW: begin
        c.id_ex_en    = 1'b1;
        c.id_ex_flush = 1'b1;
        c.ex_mem_en   = 1'b1;
        c.mem_wb_en   = 1'b1;
      end
      BRANCH: begin
        c.pc_en       = 1'b1;
        c.if_id_en    = 1'b1;
        c.if_id_flush = 1'b1;
        c.id_ex_en    = 1'b1;
        c.id_ex_flush = 1'b1;
        c.ex_mem_en   = 1'b1;
        c.mem_wb_en   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Module: regfile_scoreboard
// Per-register countdown scoreboard. A register is busy from the cycle after
// its writer issues until its value can be read from the regfile.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset (clears all counters)
//   advance_i            pipeline is moving this cycle (counters tick)
//   issue_i, issue_rd_i  an instruction writing issue_rd_i leaves ID
//   rs1_addr_i/rs2_addr_i  source registers to look up
//   rs1_busy_o/rs2_busy_o  pending write to that source (x0 never busy)
module regfile_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int WB_DIST    = DEF_WB_DIST
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  advance_i,
  input  logic                  issue_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o
);

  localparam int SB_W = $clog2(WB_DIST + 1);

  // x0 has no counter at all, so it can never look busy
  logic [SB_W-1:0]     cnt_q [1:NUM_REGS-1];
  logic [NUM_REGS-1:0] busy_vec;

  // A fresh issue (including WAW onto a still-busy register) reloads the
  // full distance; everything else counts down. Nothing moves while frozen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else if (advance_i) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue_i && (issue_rd_i == REG_ADDR_W'(r))) begin
          cnt_q[r] <= SB_W'(WB_DIST);
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy_vec    = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy_vec[r] = (cnt_q[r] != '0);
    end
  end

  assign rs1_busy_o = busy_vec[rs1_addr_i];
  assign rs2_busy_o = busy_vec[rs2_addr_i];

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Module: hazard_scoreboard_ctrl
// Pipeline controller for the non-forwarding 5-stage RV32I core. Decides each
// cycle whether the pipe runs, stalls on a RAW hazard, flushes on a taken
// branch or freezes on a data-memory wait, and drives every pipeline
// register's enable/flush accordingly.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   id_*                          instruction in decode: validity, sources, dest
//   ex_br_taken_i                 taken branch/jump resolved in EX
//   mem_req_i, mem_ack_i          outstanding dmem access and its completion
//   pc_en_o .. mem_wb_en_o        pipeline register enables / flushes
//   stall_cnt_o, flush_cnt_o      RAW-stall cycles and taken-branch flushes
module hazard_scoreboard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int WB_DIST    = DEF_WB_DIST,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic                  id_rs1_used_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
  input  logic                  id_rd_wren_i,
  input  logic                  ex_br_taken_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ack_i,
  output logic                  pc_en_o,
  output logic                  if_id_en_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_en_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_mem_en_o,
  output logic                  mem_wb_en_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  pipe_mode_e       mode;
  pipe_ctrl_t       ctrl;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             raw_hazard;
  logic             advance;
  logic             issue;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // The sources are looked up against the counters as they stand before this
  // cycle's issue, so an instruction whose rd equals its rs only waits on an
  // older writer, never on itself.
  regfile_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .REG_ADDR_W(REG_ADDR_W),
    .WB_DIST   (WB_DIST)
  ) u_scoreboard (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .advance_i (advance),
    .issue_i   (issue),
    .issue_rd_i(id_rd_addr_i),
    .rs1_addr_i(id_rs1_addr_i),
    .rs2_addr_i(id_rs2_addr_i),
    .rs1_busy_o(rs1_busy),
    .rs2_busy_o(rs2_busy)
  );

  assign raw_hazard = id_valid_i &
                      ((id_rs1_used_i & rs1_busy) | (id_rs2_used_i & rs2_busy));

  // Priority: memory wait freezes everything (a branch in EX is simply held
  // and seen again next cycle), then branch redirect, then RAW stall.
  always_comb begin
    mode = RUN;
    if (mem_req_i && !mem_ack_i) begin
      mode = MEMWAIT;
    end else if (ex_br_taken_i) begin
      mode = BRANCH;
    end else if (raw_hazard) begin
      mode = RAW;
    end
  end

  assign advance = (mode != MEMWAIT);
  assign issue   = (mode == RUN) & id_valid_i & id_rd_wren_i & (id_rd_addr_i != '0);

  // Outputs are gated by reset directly so they drop the moment rst_ni falls,
  // not on the next clock.
  assign ctrl          = mode_to_ctrl(mode);
  assign pc_en_o       = rst_ni & ctrl.pc_en;
  assign if_id_en_o    = rst_ni & ctrl.if_id_en;
  assign if_id_flush_o = rst_ni & ctrl.if_id_flush;
  assign id_ex_en_o    = rst_ni & ctrl.id_ex_en;
  assign id_ex_flush_o = rst_ni & ctrl.id_ex_flush;
  assign ex_mem_en_o   = rst_ni & ctrl.ex_mem_en;
  assign mem_wb_en_o   = rst_ni & ctrl.mem_wb_en;

  // Performance counters: one tick per RAW stall cycle and per branch flush,
  // wrapping naturally at CNT_W bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (mode == RAW) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (mode == BRANCH) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Testbench: tb_hazard_scoreboard_ctrl
// Drives a table of decode-stage scenarios one per cycle and checks the
// enable/flush pattern and perf counters against hand-derived values queued
// alongside each stimulus; reset behaviour is exercised by hand afterwards.
module tb_hazard_scoreboard_ctrl;

  // Packed as {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
  localparam logic [6:0] RUNO = 7'b1101011;
  localparam logic [6:0] RAWO = 7'b0001111;
  localparam logic [6:0] BRO  = 7'b1111111;
  localparam logic [6:0] OFFO = 7'b0000000;

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic       rs1u;
    logic [4:0] rs2;
    logic       rs2u;
    logic [4:0] rd;
    logic       wren;
    logic       br;
    logic       req;
    logic       ack;
    logic [6:0] ctrl;
    int         stall;
    int         flush;
  } vec_t;

  typedef struct {
    logic [6:0] ctrl;
    int         stall;
    int         flush;
    int         idx;
  } exp_t;

  logic        clk_i;
  logic        rst_ni;
  logic        id_valid_i;
  logic [4:0]  id_rs1_addr_i;
  logic        id_rs1_used_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_rs2_used_i;
  logic [4:0]  id_rd_addr_i;
  logic        id_rd_wren_i;
  logic        ex_br_taken_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        pc_en_o;
  logic        if_id_en_o;
  logic        if_id_flush_o;
  logic        id_ex_en_o;
  logic        id_ex_flush_o;
  logic        ex_mem_en_o;
  logic        mem_wb_en_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  int   n_cmp;
  int   n_fail;
  exp_t exp_q[$];
  vec_t tbl[$];

  hazard_scoreboard_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .id_valid_i   (id_valid_i),
    .id_rs1_addr_i(id_rs1_addr_i),
    .id_rs1_used_i(id_rs1_used_i),
    .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs2_used_i(id_rs2_used_i),
    .id_rd_addr_i (id_rd_addr_i),
    .id_rd_wren_i (id_rd_wren_i),
    .ex_br_taken_i(ex_br_taken_i),
    .mem_req_i    (mem_req_i),
    .mem_ack_i    (mem_ack_i),
    .pc_en_o      (pc_en_o),
    .if_id_en_o   (if_id_en_o),
    .if_id_flush_o(if_id_flush_o),
    .id_ex_en_o   (id_ex_en_o),
    .id_ex_flush_o(id_ex_flush_o),
    .ex_mem_en_o  (ex_mem_en_o),
    .mem_wb_en_o  (mem_wb_en_o),
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
  );

  // Free-running 10-unit clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic valid, input logic [4:0] rs1, input logic rs1u,
                              input logic [4:0] rs2, input logic rs2u,
                              input logic [4:0] rd, input logic wren, input logic br,
                              input logic req, input logic ack,
                              input logic [6:0] ctrl, input int stall, input int flush);
    vec_t v;
    v.valid = valid; v.rs1 = rs1; v.rs1u = rs1u; v.rs2 = rs2; v.rs2u = rs2u;
    v.rd = rd; v.wren = wren; v.br = br; v.req = req; v.ack = ack;
    v.ctrl = ctrl; v.stall = stall; v.flush = flush;
    return v;
  endfunction

  task automatic driveInputs(input vec_t v);
    id_valid_i    = v.valid;
    id_rs1_addr_i = v.rs1;
    id_rs1_used_i = v.rs1u;
    id_rs2_addr_i = v.rs2;
    id_rs2_used_i = v.rs2u;
    id_rd_addr_i  = v.rd;
    id_rd_wren_i  = v.wren;
    ex_br_taken_i = v.br;
    mem_req_i     = v.req;
    mem_ack_i     = v.ack;
  endtask

  task automatic pushExpect(input logic [6:0] ctrl, input int stall, input int flush, input int idx);
    exp_t e;
    e.ctrl = ctrl; e.stall = stall; e.flush = flush; e.idx = idx;
    exp_q.push_back(e);
  endtask

  // Drive one decode-stage cycle on the falling edge and queue its expectation
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk_i);
    driveInputs(v);
    pushExpect(v.ctrl, v.stall, v.flush, idx);
  endtask

  // Sample the combinational outputs mid-cycle and compare with the oldest expectation
  task automatic checkOutput();
    exp_t       e;
    logic [6:0] act;
    #3;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL queue: no expectation available");
      return;
    end
    e   = exp_q.pop_front();
    act = {pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o, ex_mem_en_o, mem_wb_en_o};
    if (act !== e.ctrl) begin
      n_fail++;
      $display("[TB] FAIL ctrl[%0d]: got %b want %b", e.idx, act, e.ctrl);
    end
    n_cmp++;
    if (stall_cnt_o !== 32'(e.stall)) begin
      n_fail++;
      $display("[TB] FAIL stall_cnt[%0d]: got %0d want %0d", e.idx, stall_cnt_o, e.stall);
    end
    n_cmp++;
    if (flush_cnt_o !== 32'(e.flush)) begin
      n_fail++;
      $display("[TB] FAIL flush_cnt[%0d]: got %0d want %0d", e.idx, flush_cnt_o, e.flush);
    end
  endtask

  initial begin
    vec_t idle;
    vec_t rdr;
    n_cmp  = 0;
    n_fail = 0;
    idle   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNO, 0, 0);

    // Back-to-back dependency x5 -> add x6,x5,x1: three stalls then issue
    tbl.push_back(mk(1, 0, 1, 0, 0, 5, 1, 0, 0, 0, RUNO, 0, 0));
    tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, RAWO, 0, 0));
    tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, RAWO, 1, 0));
    tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, RAWO, 2, 0));
    tbl.push_back(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, RUNO, 3, 0));
    // Reader of x6 stalls; a taken branch overrides the stall without counting it
    tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, RAWO, 3, 0));
    tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 1, 0, 0, BRO,  4, 0));
    tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, RAWO, 4, 1));
    tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, RUNO, 5, 1));
    // x0 writer followed by x0 reader: never a hazard
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0, RUNO, 5, 1));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, RUNO, 5, 1));
    // x7 issued, one bubble leaves cnt=2, then four frozen cycles (branch ignored)
    tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, RUNO, 5, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNO, 5, 1));
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 1, 1, 0, OFFO, 5, 1));
    end
    // Ack cycle resumes; x7 still busy for it and the next cycle
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 1, 1, RAWO, 5, 1));
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, RAWO, 6, 1));
    tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, RUNO, 7, 1));
    // WAW on x8: the second write restarts the countdown
    tbl.push_back(mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, RUNO, 7, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNO, 7, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, RUNO, 7, 1));
    tbl.push_back(mk(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, RAWO, 7, 1));
    tbl.push_back(mk(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, RAWO, 8, 1));
    tbl.push_back(mk(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, RAWO, 9, 1));
    tbl.push_back(mk(1, 0, 0, 8, 1, 0, 0, 0, 0, 0, RUNO, 10, 1));
    // rd==rs on the same instruction issues; a later rs1==rs2 reader waits three cycles
    tbl.push_back(mk(1, 9, 1, 9, 1, 9, 1, 0, 0, 0, RUNO, 10, 1));
    tbl.push_back(mk(1, 9, 1, 9, 1, 0, 0, 0, 0, 0, RAWO, 10, 1));
    tbl.push_back(mk(1, 9, 1, 9, 1, 0, 0, 0, 0, 0, RAWO, 11, 1));
    tbl.push_back(mk(1, 9, 1, 9, 1, 0, 0, 0, 0, 0, RAWO, 12, 1));
    tbl.push_back(mk(1, 9, 1, 9, 1, 0, 0, 0, 0, 0, RUNO, 13, 1));
    // A bubble naming a busy source is not a hazard
    tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, RUNO, 13, 1));
    tbl.push_back(mk(0, 10, 1, 10, 1, 0, 0, 0, 0, 0, RUNO, 13, 1));

    // Outputs must be silent while reset is held, even with idle inputs
    rst_ni = 1'b0;
    driveInputs(idle);
    pushExpect(OFFO, 0, 0, -1);
    checkOutput();
    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i], i);
      checkOutput();
    end

    // Reset pulse in the middle of a RAW stall on x11
    applyStimulus(mk(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, RUNO, 13, 1), 100);
    checkOutput();
    rdr = mk(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, RAWO, 13, 1);
    applyStimulus(rdr, 101);
    checkOutput();
    rst_ni = 1'b0;
    pushExpect(OFFO, 0, 0, 102);
    checkOutput();
    // Release with the same reader still in ID: the scoreboard was cleared
    rdr.ctrl  = RUNO;
    rdr.stall = 0;
    rdr.flush = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    pushExpect(RUNO, 0, 0, 103);
    checkOutput();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNO, 0, 0), 104);
    checkOutput();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
